// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: responder address map, initiator state encoding
// and the per-beat address helper.
package wb_pkg;

   localparam logic [31:0] WBS_MODE_ADDR  = 32'h3000_0000;
   localparam logic [31:0] WBS_DEBUG_ADDR = 32'h3000_0001;
   localparam logic [31:0] WBS_QUERY_ADDR = 32'h3100_0000;
   localparam logic [31:0] WBS_LEAF_ADDR  = 32'h3200_0000;
   localparam logic [31:0] WBS_BEST_ADDR  = 32'h3300_0000;
   localparam logic [31:0] WBS_NODE_ADDR  = 32'h3400_0000;

   typedef enum logic [1:0] {IDLE, BEAT, GAP, RESP} wbm_state_e;

   // A 64-bit word occupies two consecutive 32-bit addresses: lo at even, hi at odd.
   function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                             input logic [31:0] index,
                                             input logic        half);
      return base + (index << 1) + {31'd0, half};
   endfunction

endpackage

// File: rtl/wbm_timeout.sv
// Per-beat ack watchdog: loaded on beat entry, counts down while the beat waits,
// expired is high in the last allowed cycle of the beat.
module wbm_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = LOAD;
      else if (en && cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/wbm_ctrl.sv
// Wishbone classic-cycle initiator: one command at a time, one or two 32-bit beats
// under a single cyc, one response pulse with read data and a timeout error flag.
module wbm_ctrl
   import wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int IDX_W          = 24
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic             cmd_wide,
   input  logic             cmd_half,
   input  logic [31:0]      cmd_base,
   input  logic [IDX_W-1:0] cmd_index,
   input  logic [63:0]      cmd_wdata,
   output logic             rsp_valid,
   output logic [63:0]      rsp_rdata,
   output logic             rsp_err,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   input  logic             wbm_ack_i
);

   wbm_state_e  state_q, state_d;
   logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d, dat_q, dat_d;
   logic        wide_q, wide_d, hi_q, hi_d;
   logic [31:0] word_adr_q, word_adr_d, wdata_hi_q, wdata_hi_d;
   logic [63:0] rdata_q, rdata_d;
   logic        err_q, err_d, rsp_valid_q, rsp_valid_d, cmd_ready_q, cmd_ready_d;
   logic        tmo_clr, tmo_expired;

   // Restart the watchdog for every beat: at accept (lo/narrow) and in GAP (hi).
   assign tmo_clr = (state_q == IDLE && cmd_valid && cmd_ready_q) || (state_q == GAP);

   wbm_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .clr     (tmo_clr),
      .en      (state_q == BEAT),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      wide_d      = wide_q;
      hi_d        = hi_q;
      word_adr_d  = word_adr_q;
      wdata_hi_d  = wdata_hi_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      cmd_ready_d = cmd_ready_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d     = BEAT;
               cmd_ready_d = 1'b0;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               sel_d       = 4'hF;
               we_d        = cmd_we;
               wide_d      = cmd_wide;
               hi_d        = 1'b0;
               word_adr_d  = beat_addr(cmd_base, 32'(cmd_index), 1'b0);
               adr_d       = beat_addr(cmd_base, 32'(cmd_index), cmd_wide ? 1'b0 : cmd_half);
               dat_d       = cmd_wdata[31:0];
               wdata_hi_d  = cmd_wdata[63:32];
               rdata_d     = '0;
               err_d       = 1'b0;
            end
         end
         BEAT: begin
            // Ack wins over expiry when both land in the same cycle.
            if (wbm_ack_i) begin
               if (!we_q) begin
                  if (hi_q) rdata_d[63:32] = wbm_dat_i;
                  else      rdata_d[31:0]  = wbm_dat_i;
               end
               if (wide_q && !hi_q) begin
                  state_d = GAP;
                  stb_d   = 1'b0;
                  sel_d   = 4'h0;
               end else begin
                  state_d     = RESP;
                  cyc_d       = 1'b0;
                  stb_d       = 1'b0;
                  sel_d       = 4'h0;
                  we_d        = 1'b0;
                  rsp_valid_d = 1'b1;
               end
            end else if (tmo_expired) begin
               state_d     = RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               sel_d       = 4'h0;
               we_d        = 1'b0;
               err_d       = 1'b1;
               rsp_valid_d = 1'b1;
            end
         end
         GAP: begin
            // cyc stays up; the dropped stb lets the responder release ack first.
            state_d = BEAT;
            stb_d   = 1'b1;
            sel_d   = 4'hF;
            hi_d    = 1'b1;
            adr_d   = word_adr_q + 32'd1;
            dat_d   = wdata_hi_q;
         end
         RESP: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= 4'h0;
         adr_q       <= '0;
         dat_q       <= '0;
         wide_q      <= 1'b0;
         hi_q        <= 1'b0;
         word_adr_q  <= '0;
         wdata_hi_q  <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         wide_q      <= wide_d;
         hi_q        <= hi_d;
         word_adr_q  <= word_adr_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wbm_ctrl.sv
// Scoreboard bench for wbm_ctrl: scripted responder checks each beat, a monitor
// pops expected responses whenever rsp_valid pulses.
module tb_wbm_ctrl;
   import wb_pkg::*;

   localparam int TMO = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_wide = 1'b0, cmd_half = 1'b0;
   logic [31:0] cmd_base = '0;
   logic [23:0] cmd_index = '0;
   logic [63:0] cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err;
   logic [63:0] rsp_rdata;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;

   wbm_ctrl #(.TIMEOUT_CYCLES(TMO), .IDX_W(24)) dut (
      .wb_clk_i (wb_clk_i),  .wb_rst_ni(wb_rst_ni),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_wide (cmd_wide),  .cmd_half (cmd_half),  .cmd_base(cmd_base),
      .cmd_index(cmd_index), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
   );

   initial forever #5 wb_clk_i = ~wb_clk_i;

   // exp_len / exp_low / exp_lowcyc of -1 mean "do not check".
   typedef struct {
      logic [31:0] adr; logic we; logic [31:0] dat; int wait_c; bit noack;
      int exp_len; int exp_low; int exp_lowcyc;
   } beat_t;
   typedef struct { logic [63:0] rdata; logic err; } rsp_t;

   beat_t beat_q[$];
   rsp_t  exp_q[$];
   int    n_chk = 0, n_fail = 0, rsp_cnt = 0, n_exp = 0;
   bit    stray_req = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge wb_clk_i) begin
      if (wb_rst_ni && rsp_valid) begin
         rsp_t e;
         rsp_cnt++;
         if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected response: rdata %h err %b, none expected", rsp_rdata, rsp_err);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   // Responder: drives ack/dat_i at negedge, checks each beat as it starts and ends.
   beat_t cur;
   int    cnt_w = 0, len = 0, low_cnt = 0, lowcyc_cnt = 0;
   bit    in_beat = 1'b0;
   always @(negedge wb_clk_i) begin
      if (!wb_rst_ni || !wbm_stb_o) begin
         if (in_beat && cur.exp_len >= 0) chk("beat length", 64'(len), 64'(cur.exp_len));
         in_beat = 1'b0;
         low_cnt++;
         if (wbm_cyc_o) lowcyc_cnt++;
         wbm_ack_i = stray_req;
         wbm_dat_i = stray_req ? 32'hBAD0_BAD0 : 32'h0;
      end else begin
         if (!in_beat) begin
            in_beat = 1'b1;
            len = 0;
            if (beat_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected beat: adr %h, none expected", wbm_adr_o);
               cur = '{32'h0, 1'b0, 32'h0, 0, 1'b1, -1, -1, -1};
            end else begin
               cur = beat_q.pop_front();
               chk("beat adr", 64'(wbm_adr_o), 64'(cur.adr));
               chk("beat we", 64'(wbm_we_o), 64'(cur.we));
               chk("beat sel", 64'(wbm_sel_o), 64'hF);
               if (cur.we) chk("beat dat_o", 64'(wbm_dat_o), 64'(cur.dat));
               if (cur.exp_low >= 0) chk("stb low cycles before beat", 64'(low_cnt), 64'(cur.exp_low));
               if (cur.exp_lowcyc >= 0) chk("cyc-held gap cycles", 64'(lowcyc_cnt), 64'(cur.exp_lowcyc));
            end
            low_cnt = 0;
            lowcyc_cnt = 0;
            cnt_w = cur.wait_c;
         end
         len++;
         if (!cur.noack && cnt_w == 0) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = cur.we ? 32'h0 : cur.dat;
         end else begin
            wbm_ack_i = 1'b0;
            if (cnt_w > 0) cnt_w--;
         end
      end
   end

   task automatic issue(input logic we, input logic wide, input logic half, input logic [31:0] base,
                        input logic [23:0] idx, input logic [63:0] wd, input bit hold);
      int n = 0;
      cmd_we = we; cmd_wide = wide; cmd_half = half;
      cmd_base = base; cmd_index = idx; cmd_wdata = wd; cmd_valid = 1'b1;
      @(negedge wb_clk_i);
      while (!cmd_ready && n < 100) begin @(negedge wb_clk_i); n++; end
      if (!cmd_ready) begin
         n_chk++; n_fail++;
         $display("FAIL accept wait: cmd_ready still %b after %0d cycles, required 1", cmd_ready, n);
      end
      @(posedge wb_clk_i); #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int n = 0;
      while (rsp_cnt < target && n < 200) begin @(negedge wb_clk_i); n++; end
      n_chk++;
      if (rsp_cnt < target) begin
         n_fail++;
         $display("FAIL response wait: got %0d responses, required %0d", rsp_cnt, target);
      end
      @(posedge wb_clk_i); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("reset cmd_ready", 64'(cmd_ready), 64'h1);
      chk("reset cyc", 64'(wbm_cyc_o), 64'h0);
      chk("reset stb", 64'(wbm_stb_o), 64'h0);
      chk("reset sel", 64'(wbm_sel_o), 64'h0);
      chk("reset adr", 64'(wbm_adr_o), 64'h0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
      chk("reset rsp_rdata", rsp_rdata, 64'h0);
      @(negedge wb_clk_i); wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;

      // Wide read, lo waits two cycles, then a single GAP cycle before hi.
      beat_q.push_back('{32'h3200_000E, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, 3, -1, -1});
      beat_q.push_back('{32'h3200_000F, 1'b0, 32'h1100_1010, 0, 1'b0, 1, 1, 1});
      exp_q.push_back('{64'h1100_1010_DEAD_BEEF, 1'b0});
      issue(1'b0, 1'b1, 1'b0, WBS_LEAF_ADDR, 24'd7, 64'h0, 1'b0);
      wait_rsp(++n_exp);

      // Wide write.
      beat_q.push_back('{32'h3100_0004, 1'b1, 32'h0123_4567, 1, 1'b0, 2, -1, -1});
      beat_q.push_back('{32'h3100_0005, 1'b1, 32'h000B_CDEF, 0, 1'b0, 1, 1, 1});
      exp_q.push_back('{64'h0, 1'b0});
      issue(1'b1, 1'b1, 1'b0, WBS_QUERY_ADDR, 24'd2, 64'h000B_CDEF_0123_4567, 1'b0);
      wait_rsp(++n_exp);

      // Narrow upper-half read acked in the expiry cycle: still a success.
      beat_q.push_back('{32'h3300_0007, 1'b0, 32'hA5A5_5A5A, TMO - 1, 1'b0, TMO, -1, -1});
      exp_q.push_back('{64'h0000_0000_A5A5_5A5A, 1'b0});
      issue(1'b0, 1'b0, 1'b1, WBS_BEST_ADDR, 24'd3, 64'h0, 1'b0);
      wait_rsp(++n_exp);

      // Wide read whose hi beat is never acked.
      beat_q.push_back('{32'h3200_0020, 1'b0, 32'h1234_5678, 0, 1'b0, 1, -1, -1});
      beat_q.push_back('{32'h3200_0021, 1'b0, 32'hFFFF_FFFF, 0, 1'b1, TMO, 1, 1});
      exp_q.push_back('{64'h0000_0000_1234_5678, 1'b1});
      issue(1'b0, 1'b1, 1'b0, WBS_LEAF_ADDR, 24'h10, 64'h0, 1'b0);
      wait_rsp(++n_exp);

      // Reset pulse mid-beat: no response may appear.
      beat_q.push_back('{32'h3000_0000, 1'b1, 32'h0000_00AA, 0, 1'b1, -1, -1, -1});
      issue(1'b1, 1'b0, 1'b0, WBS_MODE_ADDR, 24'd0, 64'hAA, 1'b0);
      repeat (3) @(negedge wb_clk_i);
      #2 wb_rst_ni = 1'b0;
      #1;
      chk("reset mid-beat cyc", 64'(wbm_cyc_o), 64'h0);
      chk("reset mid-beat stb", 64'(wbm_stb_o), 64'h0);
      repeat (2) @(negedge wb_clk_i);
      chk("reset mid-beat rsp_valid", 64'(rsp_valid), 64'h0);
      #2 wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;
      chk("post-reset cmd_ready", 64'(cmd_ready), 64'h1);

      // Narrow read completes normally after the reset.
      beat_q.push_back('{32'h3400_0002, 1'b0, 32'h0000_0007, 0, 1'b0, 1, -1, -1});
      exp_q.push_back('{64'h7, 1'b0});
      issue(1'b0, 1'b0, 1'b0, WBS_NODE_ADDR, 24'd1, 64'h0, 1'b0);
      wait_rsp(++n_exp);

      // Stray ack while idle is ignored.
      stray_req = 1'b1;
      repeat (3) begin
         @(negedge wb_clk_i);
         chk("stray ack stb", 64'(wbm_stb_o), 64'h0);
         chk("stray ack cmd_ready", 64'(cmd_ready), 64'h1);
         chk("stray ack rsp_valid", 64'(rsp_valid), 64'h0);
      end
      @(posedge wb_clk_i); #1;
      stray_req = 1'b0;
      @(posedge wb_clk_i); #1;

      // Back-to-back narrow writes with cmd_valid held high.
      beat_q.push_back('{32'h3000_0000, 1'b1, 32'h0000_0001, 0, 1'b0, 1, -1, -1});
      beat_q.push_back('{32'h3000_0001, 1'b1, 32'h0000_0001, 0, 1'b0, 1, 2, 0});
      exp_q.push_back('{64'h0, 1'b0});
      exp_q.push_back('{64'h0, 1'b0});
      issue(1'b1, 1'b0, 1'b0, WBS_MODE_ADDR, 24'd0, 64'h1, 1'b1);
      r0 = rsp_cnt;
      issue(1'b1, 1'b0, 1'b0, WBS_DEBUG_ADDR, 24'd0, 64'h1, 1'b0);
      chk("b2b second accept after first response", 64'(rsp_cnt), 64'(r0 + 1));
      n_exp += 2;
      wait_rsp(n_exp);

      repeat (4) @(posedge wb_clk_i);
      #1;
      chk("leftover expected beats", 64'(beat_q.size()), 64'h0);
      chk("leftover expected responses", 64'(exp_q.size()), 64'h0);
      chk("total responses", 64'(rsp_cnt), 64'(n_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
